// File: rtl/core_pkg.sv
// +-----------------------------------------------------------------------------+
// | core_pkg : shared fetch-stage types and widths                               |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
`default_nettype none

package core_pkg;

  localparam int INST_W = 32;
  localparam int ADDR_W = 32;
  localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    FLUSH = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] command;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// +-----------------------------------------------------------------------------+
// | fetch_fifo : power-of-two FIFO with clear, occupancy count and head output   |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
`default_nettype none

module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic [WIDTH-1:0]           head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;
  logic             full;

  always_comb begin
    do_pop   = pop && (count_q != '0) && !clear;
    do_push  = push && !clear;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign head  = mem_q[rd_ptr_q];

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !clear && !pop && full));

endmodule

`default_nettype wire

// File: rtl/fetch_queue.sv
// +-----------------------------------------------------------------------------+
// | fetch_queue : in-order imem fetch with PC-tagged queue and redirect flush    |
// | Option FETCH_BYPASS_EN: same-cycle rvalid -> inst_valid when queue is empty  |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
`default_nettype none

module fetch_queue
  import core_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter int          MAX_OUTST = 2,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              stall,
  output logic              inst_valid,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [INST_W-1:0] inst_command
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUTST + 1);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] ret_pc_q, ret_pc_d;
  logic [OW-1:0]     outst_q, outst_d, outst_next;
  logic [OW-1:0]     drop_q, drop_d;

  logic              fifo_clear, fifo_push, fifo_pop, fifo_empty;
  logic [CW-1:0]     fifo_count;
  fetch_entry_t      push_entry, head_entry;
  logic              issue, can_issue, bypass_hit;

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (fifo_clear),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .head      (head_entry)
  );

  // Queue slots are reserved at issue time, so a returning word always fits.
  assign can_issue  = ((int'(fifo_count) + int'(outst_q)) < DEPTH) && (int'(outst_q) < MAX_OUTST);
  assign issue      = imem_req && imem_gnt;
  assign outst_next = outst_q + OW'(issue) - OW'(imem_rvalid);
  assign push_entry = '{pc: ret_pc_q, command: imem_rdata};

`ifdef FETCH_BYPASS_EN
  assign bypass_hit = imem_rvalid && fifo_empty && (state_q == FETCH) && !redirect;
`else
  assign bypass_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      fetch_pc_q <= RESET_PC;
      ret_pc_q   <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      ret_pc_q   <= ret_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (redirect) begin
      state_d = (outst_next != '0) ? FLUSH : FETCH;
    end else if ((state_q == FLUSH) && imem_rvalid && (drop_q == OW'(1))) begin
      state_d = FETCH;
    end
  end

  always_comb begin
    imem_req     = !rst && (state_q == FETCH) && can_issue;
    imem_addr    = fetch_pc_q;
    inst_valid   = 1'b0;
    inst_pc      = '0;
    inst_command = '0;
    if (!rst) begin
      if (!fifo_empty) begin
        inst_valid   = 1'b1;
        inst_pc      = head_entry.pc;
        inst_command = head_entry.command;
      end else if (bypass_hit) begin
        inst_valid   = 1'b1;
        inst_pc      = ret_pc_q;
        inst_command = imem_rdata;
      end
    end
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    ret_pc_d   = ret_pc_q;
    outst_d    = outst_next;
    drop_d     = drop_q;
    fifo_clear = 1'b0;
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    if (redirect) begin
      // Everything still in flight after this cycle belongs to the old path.
      fifo_clear = 1'b1;
      fetch_pc_d = redirect_pc;
      ret_pc_d   = redirect_pc;
      drop_d     = outst_next;
    end else begin
      if (issue) fetch_pc_d = fetch_pc_q + PC_STEP;
      if (state_q == FLUSH) begin
        if (imem_rvalid) drop_d = drop_q - OW'(1);
      end else begin
        fifo_pop = !fifo_empty && !stall;
        if (imem_rvalid) begin
          ret_pc_d  = ret_pc_q + PC_STEP;
          fifo_push = !(bypass_hit && !stall);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// +-----------------------------------------------------------------------------+
// | tb_fetch_queue : directed + random bench with in-order imem and stream model |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        inst_valid;
  logic [31:0] inst_pc;
  logic [31:0] inst_command;

`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  fetch_queue dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .stall        (stall),
    .inst_valid   (inst_valid),
    .inst_pc      (inst_pc),
    .inst_command (inst_command)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        mq[$];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          last_due = 0;
  int          lat_min  = 1;
  int          lat_max  = 1;
  logic [31:0] exp_pc, exp_issue;
  logic        s_req, s_iv, s_rv;
  int          n_out;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; stall = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check_eq("rst_req", {31'b0, imem_req}, 32'd0);
    check_eq("rst_valid", {31'b0, inst_valid}, 32'd0);
    check_eq("rst_pc", inst_pc, 32'd0);
    check_eq("rst_cmd", inst_command, 32'd0);
    rst = 1'b0;
    mq.delete();
    exp_pc    = 32'h0;
    exp_issue = 32'h0;
    last_due  = cyc;
    #1;
    check_eq("post_rst_req", {31'b0, imem_req}, 32'd1);
    check_eq("post_rst_addr", imem_addr, 32'h0);
    check_eq("post_rst_valid", {31'b0, inst_valid}, 32'd0);
  endtask

  // One clock: drive memory/decode inputs, check against the stream model, advance.
  task automatic run_cycle(input bit rd, input logic [31:0] rpc, input bit stl, input bit gnt);
    int d;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mq[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom();
    end
    imem_gnt = gnt; stall = stl; redirect = rd; redirect_pc = rpc;
    #1;
    s_req = imem_req; s_iv = inst_valid; s_rv = imem_rvalid;
    if (!inst_valid) begin
      check_eq("idle_pc", inst_pc, 32'd0);
      check_eq("idle_cmd", inst_command, 32'd0);
    end
    if (inst_valid && !stall && !redirect) begin
      check_eq("inst_pc", inst_pc, exp_pc);
      check_eq("inst_cmd", inst_command, mem_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
    end
    if (imem_rvalid) void'(mq.pop_front());
    if (imem_req && imem_gnt) begin
      check_eq("imem_addr", imem_addr, exp_issue);
      d = cyc + int'($urandom_range(lat_min, lat_max));
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      mq.push_back('{addr: imem_addr, due: d});
      exp_issue = exp_issue + 32'd4;
      check_eq("outst_max", {31'b0, (mq.size() <= 2)}, 32'd1);
    end
    if (redirect) begin
      exp_pc    = rpc;
      exp_issue = rpc;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  initial begin
    rst = 1'b1;
    do_reset();

    // Reset latency and steady stream with 1-cycle memory.
    run_cycle(0, 0, 0, 1);
    check_eq("lat_c0_valid", {31'b0, s_iv}, 32'd0);
    run_cycle(0, 0, 0, 1);
    check_eq("lat_c1_rvalid", {31'b0, s_rv}, 32'd1);
    check_eq("lat_c1_valid", {31'b0, s_iv}, {31'b0, BYP});
    run_cycle(0, 0, 0, 1);
    check_eq("lat_c2_valid", {31'b0, s_iv}, 32'd1);
    for (int i = 0; i < 20; i++) run_cycle(0, 0, 0, 1);
    check_eq("t1_stream_len", exp_pc, BYP ? 32'd88 : 32'd84);

    // Hold decode off: queue fills, requests stop, then drains in order.
    for (int i = 0; i < 10; i++) run_cycle(0, 0, 1, 1);
    check_eq("t2_req_drop", {31'b0, s_req}, 32'd0);
    check_eq("t2_valid", {31'b0, s_iv}, 32'd1);
    for (int i = 0; i < 15; i++) run_cycle(0, 0, 0, 1);

    // Redirect with two requests in flight on a 3-cycle memory.
    lat_min = 3; lat_max = 3;
    for (int k = 0; k < 20 && mq.size() != 2; k++) run_cycle(0, 0, 0, 1);
    check_eq("t3_setup", mq.size(), 32'd2);
    run_cycle(1, 32'h100, 0, 1);
    n_out = mq.size();
    run_cycle(0, 0, 0, 1);
    check_eq("t3_flush_req", {31'b0, s_req}, {31'b0, (n_out == 0)});
    check_eq("t3_flush_valid", {31'b0, s_iv}, 32'd0);
    for (int i = 0; i < 14; i++) run_cycle(0, 0, 0, 1);
    check_eq("t3_progress", {31'b0, (exp_pc > 32'h100)}, 32'd1);

    // Redirect coinciding with return, pop and issue.
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 8; i++) run_cycle(0, 0, 0, 1);
    run_cycle(1, 32'h200, 0, 1);
    check_eq("t4_rvalid", {31'b0, s_rv}, 32'd1);
    check_eq("t4_issue", {31'b0, s_req}, 32'd1);
    if (!BYP) check_eq("t4_pop", {31'b0, s_iv}, 32'd1);
    for (int i = 0; i < 8; i++) run_cycle(0, 0, 0, 1);
    check_eq("t4_progress", {31'b0, (exp_pc > 32'h200)}, 32'd1);

    // Fetch across the top of the address space.
    run_cycle(1, 32'hFFFF_FFFC, 0, 1);
    for (int i = 0; i < 10; i++) run_cycle(0, 0, 0, 1);
    check_eq("t5_wrap", {31'b0, (exp_pc >= 32'h4 && exp_pc < 32'h40)}, 32'd1);

    // Reset while flushing, then repeat the latency check.
    lat_min = 3; lat_max = 3;
    for (int k = 0; k < 20 && mq.size() != 2; k++) run_cycle(0, 0, 0, 1);
    run_cycle(1, 32'h300, 0, 1);
    check_eq("t6_in_flush", {31'b0, (mq.size() > 0)}, 32'd1);
    do_reset();
    lat_min = 1; lat_max = 1;
    run_cycle(0, 0, 0, 1);
    run_cycle(0, 0, 0, 1);
    check_eq("t6_lat_valid", {31'b0, s_iv}, {31'b0, BYP});
    run_cycle(0, 0, 0, 1);
    check_eq("t6_lat_next", {31'b0, s_iv}, 32'd1);

    // Random traffic: variable latency, grant, stall, redirects and resets.
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rp;
      rp = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
      if ($urandom_range(0, 999) < 3) begin
        do_reset();
      end else begin
        run_cycle($urandom_range(0, 99) < 3, rp, $urandom_range(0, 99) < 30,
                  $urandom_range(0, 99) < 70);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
